// File: rtl/pwm_led_bank.sv
// Multi-channel PWM LED driver with a shared prescaler/period counter and per-channel duty shadowing.
// Optional breathing mode is enabled by defining BREATHE_EN (adds the breathe port and STEP parameter).
module pwm_led_bank #(
  parameter int          CH        = 8,
  parameter int          W         = 4,
  parameter int          PRESCALE  = 256,
  parameter int unsigned DUTY_INIT = 0
`ifdef BREATHE_EN
  ,
  parameter int          STEP      = 1
`endif
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  en,
  input  logic                                  wr_en,
  input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0] wr_addr,
  input  logic [W-1:0]                          wr_data,
`ifdef BREATHE_EN
  input  logic [CH-1:0]                         breathe,
`endif
  output logic [CH-1:0]                         led,
  output logic                                  period_tick
);

  localparam int AW = (CH > 1) ? $clog2(CH) : 1;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);
  localparam logic [W-1:0]  INIT_W  = W'(DUTY_INIT);

  logic [PW-1:0] pre_cnt;
  logic [W-1:0]  cnt;
  logic [W-1:0]  duty_reg [CH];
  logic [W-1:0]  act      [CH];
  logic          tick;
  logic          boundary;

  assign tick     = en && (pre_cnt == PRE_MAX);
  assign boundary = tick && (&cnt);

  // Prescaler and period counter freeze while en is low so the phase resumes where it stopped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt     <= '0;
      cnt         <= '0;
      period_tick <= 1'b0;
    end else begin
      period_tick <= boundary;
      if (en) begin
        if (tick) begin
          pre_cnt <= '0;
          cnt     <= cnt + 1'b1;
        end else begin
          pre_cnt <= pre_cnt + 1'b1;
        end
      end
    end
  end

  // Out-of-range addresses simply match no channel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CH; i++) duty_reg[i] <= INIT_W;
    end else if (wr_en) begin
      for (int i = 0; i < CH; i++) begin
        if (wr_addr == AW'(i)) duty_reg[i] <= wr_data;
      end
    end
  end

`ifdef BREATHE_EN
  localparam logic [W:0]   STEP_X = (W+1)'(STEP);
  localparam logic [W-1:0] STEP_W = W'(STEP);

  logic [CH-1:0] dir_down;

  // Returns {dir_down, act} for one breathing step; widened compares avoid wrap at the top.
  function automatic logic [W:0] breathe_step(input logic [W-1:0] cur,
                                              input logic [W-1:0] peak,
                                              input logic         down);
    logic [W:0] c;
    logic [W:0] p;
    c = {1'b0, cur};
    p = {1'b0, peak};
    if (c > p) return {1'b1, peak};
    if (!down) begin
      if (c + STEP_X >= p) return {1'b1, peak};
      return {1'b0, cur + STEP_W};
    end
    if (c <= STEP_X) return {1'b0, {W{1'b0}}};
    return {1'b1, cur - STEP_W};
  endfunction
`endif

  // Active duty is reloaded only at the period boundary, from the pre-write duty value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CH; i++) act[i] <= INIT_W;
      led <= '0;
`ifdef BREATHE_EN
      dir_down <= '0;
`endif
    end else begin
      for (int i = 0; i < CH; i++) led[i] <= en && (cnt < act[i]);
      if (boundary) begin
        for (int i = 0; i < CH; i++) begin
`ifdef BREATHE_EN
          if (breathe[i]) begin
            {dir_down[i], act[i]} <= breathe_step(act[i], duty_reg[i], dir_down[i]);
          end else begin
            act[i]      <= duty_reg[i];
            dir_down[i] <= 1'b0;
          end
`else
          act[i] <= duty_reg[i];
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_led_bank.sv
// Self-checking bench for pwm_led_bank: arithmetic reference model, per-cycle compare, directed and random stimulus.
// Define BREATHE_EN to also exercise the breathing mode.
module tb_pwm_led_bank;

  localparam int CH       = 5;
  localparam int W        = 4;
  localparam int PRESCALE = 2;
  localparam int PER      = 16;
  localparam int FULL     = PRESCALE * PER;
`ifdef BREATHE_EN
  localparam int STEP     = 4;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic          wr_en;
  logic [2:0]    wr_addr;
  logic [W-1:0]  wr_data;
`ifdef BREATHE_EN
  logic [CH-1:0] breathe;
`endif
  logic [CH-1:0] led;
  logic          period_tick;

  pwm_led_bank #(
    .CH(CH), .W(W), .PRESCALE(PRESCALE), .DUTY_INIT(0)
`ifdef BREATHE_EN
    , .STEP(STEP)
`endif
  ) dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
`ifdef BREATHE_EN
    .breathe(breathe),
`endif
    .led(led),
    .period_tick(period_tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  // Reference model: position in the period is derived from the count of enabled cycles.
  longint        en_cyc;
  int            m_duty [CH];
  int            m_act  [CH];
  bit            m_down [CH];
  logic [CH-1:0] exp_led;
  logic          exp_tick;

  initial begin
    int cntv;
    bit bnd;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        en_cyc   = 0;
        exp_led  = '0;
        exp_tick = 1'b0;
        for (int i = 0; i < CH; i++) begin
          m_duty[i] = 0;
          m_act[i]  = 0;
          m_down[i] = 1'b0;
        end
      end else begin
        cntv = int'((en_cyc / PRESCALE) % PER);
        bnd  = en && (((en_cyc + 1) % FULL) == 0);
        for (int i = 0; i < CH; i++) exp_led[i] = en && (cntv < m_act[i]);
        exp_tick = bnd;
        if (bnd) begin
          for (int i = 0; i < CH; i++) begin
`ifdef BREATHE_EN
            if (breathe[i]) begin
              if (!m_down[i]) begin
                if (m_act[i] + STEP >= m_duty[i]) begin
                  m_act[i] = m_duty[i]; m_down[i] = 1'b1;
                end else begin
                  m_act[i] = m_act[i] + STEP;
                end
              end else if (m_act[i] > m_duty[i]) begin
                m_act[i] = m_duty[i];
              end else if (m_act[i] <= STEP) begin
                m_act[i] = 0; m_down[i] = 1'b0;
              end else begin
                m_act[i] = m_act[i] - STEP;
              end
            end else begin
              m_act[i] = m_duty[i]; m_down[i] = 1'b0;
            end
`else
            m_act[i] = m_duty[i];
`endif
          end
        end
        if (wr_en && (int'(wr_addr) < CH)) m_duty[int'(wr_addr)] = int'(wr_data);
        if (en) en_cyc++;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison of the DUT against the model.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (chk_on) begin
        checkOutput("led", 32'(led), 32'(exp_led));
        checkOutput("period_tick", 32'(period_tick), 32'(exp_tick));
      end
    end
  end

  task automatic applyStimulus(input logic e, input logic we, input logic [2:0] a, input logic [W-1:0] d);
    @(negedge clk);
    en      = e;
    wr_en   = we;
    wr_addr = a;
    wr_data = d;
  endtask

  task automatic writeDuty(input logic [2:0] a, input logic [W-1:0] d);
    applyStimulus(en, 1'b1, a, d);
    applyStimulus(en, 1'b0, a, d);
  endtask

  int hi_cnt [CH];
  int tick_cnt;
  logic last_tick;

  task automatic countHigh(input int n);
    for (int i = 0; i < CH; i++) hi_cnt[i] = 0;
    tick_cnt  = 0;
    last_tick = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #2;
      for (int i = 0; i < CH; i++) if (led[i]) hi_cnt[i]++;
      if (period_tick) tick_cnt++;
      last_tick = period_tick;
    end
  endtask

  task automatic waitTick(input int bound);
    bit found;
    found = 1'b0;
    for (int k = 0; k < bound; k++) begin
      @(posedge clk);
      #2;
      if (period_tick) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("wait_tick", 32'(found), 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0; en = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
`ifdef BREATHE_EN
    breathe = '0;
`endif
    #2 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset  = 1'b0;
    en     = 1'b1;
    chk_on = 1'b1;
    checkOutput("reset_led", 32'(led), 32'd0);
    checkOutput("reset_tick", 32'(period_tick), 32'd0);

    $display("[TB] duty 4 / 0 / 15 and period spacing");
    writeDuty(3'd0, 4'd4);
    writeDuty(3'd1, 4'd0);
    writeDuty(3'd2, 4'd15);
    waitTick(80);
    countHigh(32);
    checkOutput("ch0_high_4", 32'(hi_cnt[0]), 32'd8);
    checkOutput("ch1_high_0", 32'(hi_cnt[1]), 32'd0);
    checkOutput("ch2_high_15", 32'(hi_cnt[2]), 32'd30);
    checkOutput("ticks_per_period", 32'(tick_cnt), 32'd1);
    checkOutput("tick_at_32", 32'(last_tick), 32'd1);

    $display("[TB] mid-period write then write on the boundary cycle");
    repeat (10) @(negedge clk);
    writeDuty(3'd3, 4'd8);
    repeat (19) @(negedge clk);
    writeDuty(3'd3, 4'd2);
    countHigh(32);
    checkOutput("ch3_first_period", 32'(hi_cnt[3]), 32'd16);
    countHigh(32);
    checkOutput("ch3_second_period", 32'(hi_cnt[3]), 32'd4);

    $display("[TB] out-of-range addresses");
    writeDuty(3'd7, 4'd9);
    writeDuty(3'd5, 4'd11);
    waitTick(80);
    countHigh(32);
    checkOutput("oor_ch0", 32'(hi_cnt[0]), 32'd8);
    checkOutput("oor_ch2", 32'(hi_cnt[2]), 32'd30);
    checkOutput("oor_ch3", 32'(hi_cnt[3]), 32'd4);

    $display("[TB] async reset mid-high, then en hold");
    waitTick(80);
    countHigh(2);
    checkOutput("ch0_high_before_reset", 32'(led[0]), 32'd1);
    #1 reset = 1'b1;
    #1 checkOutput("led_on_reset", 32'(led), 32'd0);
    checkOutput("tick_on_reset", 32'(period_tick), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    writeDuty(3'd0, 4'd4);
    waitTick(80);
    countHigh(3);
    checkOutput("ch0_before_hold", 32'(hi_cnt[0]), 32'd3);
    applyStimulus(1'b0, 1'b0, 3'd0, 4'd0);
    countHigh(10);
    checkOutput("ch0_during_hold", 32'(hi_cnt[0]), 32'd0);
    checkOutput("ticks_during_hold", 32'(tick_cnt), 32'd0);
    applyStimulus(1'b1, 1'b0, 3'd0, 4'd0);
    countHigh(8);
    checkOutput("ch0_after_resume", 32'(hi_cnt[0]), 32'd5);

`ifdef BREATHE_EN
    $display("[TB] breathing on ch0, peak 12, step 4");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    writeDuty(3'd0, 4'd12);
    @(negedge clk);
    breathe = 5'b00001;
    waitTick(80);
    countHigh(32);
    checkOutput("breathe_act4", 32'(hi_cnt[0]), 32'd8);
    begin
      int seq [6] = '{16, 24, 16, 8, 0, 8};
      for (int k = 0; k < 6; k++) begin
        countHigh(32);
        checkOutput("breathe_seq", 32'(hi_cnt[0]), 32'(seq[k]));
      end
    end
    countHigh(16);
    checkOutput("breathe_act8", 32'(hi_cnt[0]), 32'd16);
    writeDuty(3'd0, 4'd6);
    countHigh(15);
    checkOutput("breathe_act8_tail", 32'(hi_cnt[0]), 32'd0);
    countHigh(32);
    checkOutput("breathe_clamp6", 32'(hi_cnt[0]), 32'd12);
    countHigh(32);
    checkOutput("breathe_down2", 32'(hi_cnt[0]), 32'd4);
    @(negedge clk);
    breathe = '0;
`endif

    $display("[TB] randomized traffic");
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 399) == 0) begin
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
`ifdef BREATHE_EN
      if ($urandom_range(0, 63) == 0) breathe = CH'($urandom());
`endif
      applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0,
                    3'($urandom_range(0, 7)), W'($urandom()));
    end
    applyStimulus(1'b1, 1'b0, 3'd0, 4'd0);
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
